circuit1_hlsm: RTL and testbench

Multi-cycle, resource-shared implementation of the circuit1 dataflow (d=a+b, e=a+c, g=d>e, z=g?d:e, f=a*c, x=f-d) under a Start/Done handshake. One adder/subtractor, one multiplier and one comparator are time-multiplexed by a small FSM (finite-state machine). The block is the sequential, scheduled counterpart of the combinational circuit1 datapath. It serves as the target the team's HLSM scheduling flow must reproduce.

---
 rtl/hlsm_pkg.sv | 39 +++
 rtl/circuit1_hlsm_dp.sv | 81 ++++++++
 rtl/circuit1_hlsm.sv | 87 ++++++++
 tb/tb_circuit1_hlsm.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/hlsm_pkg.sv
// Shared types and constants for the circuit1 HLSM: state encoding,
// default operand width, addsub mode/operand selects and the FSM-to-datapath control bundle.
package hlsm_pkg;

  localparam int unsigned DATAWIDTH = 8;

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_S1    = 3'd1,
    ST_S2    = 3'd2,
    ST_S3    = 3'd3,
    ST_S4    = 3'd4,
    ST_FINAL = 3'd5
  } state_t;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } addsub_mode_t;

  typedef enum logic [1:0] {
    SEL_AB = 2'd0,
    SEL_AC = 2'd1,
    SEL_FD = 2'd2
  } addsub_sel_t;

  typedef struct packed {
    logic         ld_op;
    addsub_sel_t  add_sel;
    addsub_mode_t add_mode;
    logic         ld_d;
    logic         ld_e;
    logic         ld_f;
    logic         ld_g;
    logic         ld_xw;
    logic         ld_out;
  } dp_ctrl_t;

endpackage

// File: rtl/circuit1_hlsm_dp.sv
// Datapath for circuit1_hlsm: operand/intermediate/output registers around one
// shared addsub, one multiplier and one signed comparator, steered by the FSM.
module circuit1_hlsm_dp
  import hlsm_pkg::*;
#(
  parameter int unsigned DATAWIDTH = hlsm_pkg::DATAWIDTH
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  dp_ctrl_t                 ctrl,
  input  logic [DATAWIDTH-1:0]     a,
  input  logic [DATAWIDTH-1:0]     b,
  input  logic [DATAWIDTH-1:0]     c,
  output logic [DATAWIDTH-1:0]     z,
  output logic [2*DATAWIDTH-1:0]   x
);

  localparam int unsigned W = DATAWIDTH;

  logic [W-1:0]   ra, rb, rc, rd, re, rz;
  logic [2*W-1:0] rf, rxw, rx;
  logic           rg;

  logic [2*W-1:0] op_l, op_r, sum, prod;
  logic           gt;

  function automatic logic [2*W-1:0] sext(input logic [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction

  // The addsub always works at 2W bits; d and e keep the low W bits, which
  // gives the required modulo-2^W wrap for the W-bit sums.
  always_comb begin
    op_l = '0;
    op_r = '0;
    case (ctrl.add_sel)
      SEL_AB: begin op_l = sext(ra); op_r = sext(rb); end
      SEL_AC: begin op_l = sext(ra); op_r = sext(rc); end
      SEL_FD: begin op_l = rf;       op_r = sext(rd); end
      default: begin op_l = '0;      op_r = '0;       end
    endcase
    sum = (ctrl.add_mode == SUB) ? (op_l - op_r) : (op_l + op_r);
  end

  assign prod = $signed(sext(ra)) * $signed(sext(rc));
  assign gt   = $signed(rd) > $signed(re);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ra  <= '0;
      rb  <= '0;
      rc  <= '0;
      rd  <= '0;
      re  <= '0;
      rf  <= '0;
      rg  <= 1'b0;
      rxw <= '0;
      rz  <= '0;
      rx  <= '0;
    end else begin
      if (ctrl.ld_op) begin
        ra <= a;
        rb <= b;
        rc <= c;
      end
      if (ctrl.ld_d)  rd  <= sum[W-1:0];
      if (ctrl.ld_e)  re  <= sum[W-1:0];
      if (ctrl.ld_f)  rf  <= prod;
      if (ctrl.ld_g)  rg  <= gt;
      if (ctrl.ld_xw) rxw <= sum;
      if (ctrl.ld_out) begin
        rz <= rg ? rd : re;
        rx <= rxw;
      end
    end
  end

  assign z = rz;
  assign x = rx;

endmodule

// File: rtl/circuit1_hlsm.sv
// circuit1 dataflow scheduled over Wait/S1..S4/Final with a Start/Done handshake.
// Define HLSM_BUSY_EN to add the Busy output (high in every state except Wait).
module circuit1_hlsm
  import hlsm_pkg::*;
#(
  parameter int unsigned DATAWIDTH = hlsm_pkg::DATAWIDTH
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Start,
  input  logic [DATAWIDTH-1:0]     a,
  input  logic [DATAWIDTH-1:0]     b,
  input  logic [DATAWIDTH-1:0]     c,
  output logic                     Done,
  output logic [DATAWIDTH-1:0]     z,
  output logic [2*DATAWIDTH-1:0]   x
`ifdef HLSM_BUSY_EN
  ,
  output logic                     Busy
`endif
);

  state_t   state_q, state_d;
  dp_ctrl_t ctrl;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= ST_WAIT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      ST_WAIT: begin
        if (Start) begin
          ctrl.ld_op = 1'b1;
          state_d    = ST_S1;
        end
      end
      ST_S1: begin
        ctrl.add_sel  = SEL_AB;
        ctrl.add_mode = ADD;
        ctrl.ld_d     = 1'b1;
        ctrl.ld_f     = 1'b1;
        state_d       = ST_S2;
      end
      ST_S2: begin
        ctrl.add_sel  = SEL_AC;
        ctrl.add_mode = ADD;
        ctrl.ld_e     = 1'b1;
        state_d       = ST_S3;
      end
      ST_S3: begin
        ctrl.add_sel  = SEL_FD;
        ctrl.add_mode = SUB;
        ctrl.ld_g     = 1'b1;
        ctrl.ld_xw    = 1'b1;
        state_d       = ST_S4;
      end
      ST_S4: begin
        ctrl.ld_out = 1'b1;
        state_d     = ST_FINAL;
      end
      ST_FINAL: state_d = ST_WAIT;
      default:  state_d = ST_WAIT;
    endcase
  end

  // Decoded from the registered state so an async reset drops Done at once.
  assign Done = (state_q == ST_FINAL);
`ifdef HLSM_BUSY_EN
  assign Busy = (state_q != ST_WAIT);
`endif

  circuit1_hlsm_dp #(.DATAWIDTH(DATAWIDTH)) u_dp (
    .Clk  (Clk),
    .Rst  (Rst),
    .ctrl (ctrl),
    .a    (a),
    .b    (b),
    .c    (c),
    .z    (z),
    .x    (x)
  );

endmodule

// File: tb/tb_circuit1_hlsm.sv
// Self-checking bench for circuit1_hlsm: directed cases, randomized transactions
// with mid-operation perturbation, reset abort and back-to-back Start.
module tb_circuit1_hlsm;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [7:0]  a = '0, b = '0, c = '0;
  logic        Done;
  logic [7:0]  z;
  logic [15:0] x;
`ifdef HLSM_BUSY_EN
  logic        Busy;
`endif

  int vectors = 0;
  int miscompares = 0;

  circuit1_hlsm #(.DATAWIDTH(8)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .a     (a),
    .b     (b),
    .c     (c),
    .Done  (Done),
    .z     (z),
    .x     (x)
`ifdef HLSM_BUSY_EN
    ,
    .Busy  (Busy)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: evaluate the dataflow directly on signed integers.
  function automatic void model(input byte ia, input byte ib, input byte ic,
                                output logic [7:0] ez, output logic [15:0] ex);
    byte d, e;
    int  f;
    d  = byte'(int'(ia) + int'(ib));
    e  = byte'(int'(ia) + int'(ic));
    f  = int'(ia) * int'(ic);
    ez = (d > e) ? d : e;
    ex = 16'(f - int'(d));
  endfunction

  task automatic do_txn(input byte ia, input byte ib, input byte ic,
                        input bit perturb, input bit release_rst);
    int edges;
    int busy_cnt;
    int extra_done;
    logic [7:0]  ez;
    logic [15:0] ex;
    model(ia, ib, ic, ez, ex);
    @(negedge Clk);
    if (release_rst) Rst = 1'b1;
    Start = 1'b1; a = ia; b = ib; c = ic;
    @(negedge Clk);
    edges = 1;
    busy_cnt = 0;
    while (!Done && edges < 20) begin
`ifdef HLSM_BUSY_EN
      busy_cnt += int'(Busy);
`endif
      if (perturb && (edges == 2 || edges == 3)) begin
        Start = 1'($urandom);
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      end else begin
        Start = 1'b0;
      end
      @(negedge Clk);
      edges++;
    end
    Start = 1'b0;
`ifdef HLSM_BUSY_EN
    busy_cnt += int'(Busy);
    check("busy_cycles", busy_cnt, 5);
`endif
    check("latency", edges, 5);
    check("z", z, ez);
    check("x", x, ex);
    @(negedge Clk);
    check("done_pulse", Done, 0);
`ifdef HLSM_BUSY_EN
    check("busy_idle", Busy, 0);
`endif
    check("z_hold", z, ez);
    check("x_hold", x, ex);
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      extra_done += int'(Done);
    end
    check("extra_done", extra_done, 0);
  endtask

  initial begin
    int q_done[$];
    logic [7:0]  ez;
    logic [15:0] ex;

    #1;
    check("rst_done", Done, 0);
    check("rst_z", z, 0);
    check("rst_x", x, 0);
`ifdef HLSM_BUSY_EN
    check("rst_busy", Busy, 0);
`endif
    #20 Rst = 1'b1;

    do_txn(8'sd3, 8'sd4, 8'sd2, 1'b0, 1'b0);
    check("s1_z_const", z, 8'h07);
    check("s1_x_const", x, 16'hFFFF);
    do_txn(8'sd1, 8'sd0, 8'sd5, 1'b0, 1'b0);
    check("s2_z_const", z, 8'h06);
    check("s2_x_const", x, 16'h0004);
    do_txn(8'sd100, 8'sd100, -8'sd128, 1'b0, 1'b0);
    check("s3_z_const", z, 8'hE4);
    check("s3_x_const", x, 16'hCE38);
    do_txn(-8'sd7, 8'sd12, 8'sd33, 1'b1, 1'b0);

    // Abort in S3: outputs must clear asynchronously.
    @(negedge Clk);
    Start = 1'b1; a = 8'd3; b = 8'd4; c = 8'd2;
    @(negedge Clk); Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    check("abort_done", Done, 0);
    check("abort_z", z, 0);
    check("abort_x", x, 0);
    repeat (3) begin
      @(negedge Clk);
      check("abort_nodone", Done, 0);
    end
    do_txn(8'sd3, 8'sd4, 8'sd2, 1'b0, 1'b1);

    for (int n = 0; n < 20; n++)
      do_txn(byte'($urandom), byte'($urandom), byte'($urandom), 1'($urandom), 1'b0);

    // Held Start: back-to-back transactions.
    model(-8'sd50, 8'sd77, -8'sd3, ez, ex);
    @(negedge Clk);
    Start = 1'b1; a = 8'hCE; b = 8'd77; c = 8'hFD;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (Done) begin
        q_done.push_back(i);
        check("held_z", z, ez);
        check("held_x", x, ex);
        if (q_done.size() == 3) begin
          Start = 1'b0;
          break;
        end
      end
    end
    Start = 1'b0;
    check("held_count", q_done.size(), 3);
    if (q_done.size() == 3) begin
      check("held_first", q_done[0], 5);
      check("held_gap1", q_done[1] - q_done[0], 6);
      check("held_gap2", q_done[2] - q_done[1], 6);
    end
    repeat (8) begin
      @(negedge Clk);
      check("held_stop", Done, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
